// File: rtl/anemo_pkg.sv
// Shared constants for the anemometer meter: register map, CTRL bit layout
// and FSM state codes as seen in STAT.
package anemo_pkg;

    localparam logic [1:0] ADDR_CTRL = 2'd0;
    localparam logic [1:0] ADDR_DATA = 2'd1;
    localparam logic [1:0] ADDR_STAT = 2'd2;

    localparam int CTRL_RAZ_N_BIT   = 0;
    localparam int CTRL_CONTINU_BIT = 1;
    localparam int CTRL_START_BIT   = 2;
    localparam int DATA_VALID_BIT   = 16;
    localparam int STAT_BUSY_BIT    = 0;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    typedef struct packed {
        logic start_stop;
        logic continu;
        logic raz_n;
    } ctrl_t;

endpackage

// File: rtl/anemo_pulse_filter.sv
// Anemometer input conditioning: 2-FF synchroniser, stability filter and a
// one-cycle strobe on each accepted rising edge of the filtered level.
module anemo_pulse_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic in_anemo,
    output logic strobe
);

    localparam int CW = $clog2(FILT_LEN + 1);

    logic          sync_1;
    logic          sync_2;
    logic          filt;
    logic          filt_d;
    logic [CW-1:0] stable_cnt;

    // filt only follows sync_2 once it has disagreed for FILT_LEN consecutive samples
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            filt       <= 1'b0;
            filt_d     <= 1'b0;
            stable_cnt <= '0;
            strobe     <= 1'b0;
        end else begin
            sync_1 <= in_anemo;
            sync_2 <= sync_1;
            if (sync_2 == filt) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CW'(FILT_LEN - 1)) begin
                filt       <= sync_2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CW'(1);
            end
            filt_d <= filt;
            strobe <= filt & ~filt_d;
        end
    end

endmodule

// File: rtl/avalon_anemo_meter.sv
// Avalon-MM anemometer frequency meter: counts filtered pulses over a fixed
// gate window, continuous or single-shot, with a software hold-clear.
//
//  state   | meaning
//  IDLE    | held clear or waiting for the first start
//  MEASURE | gate running, pulses being counted
//  DONE    | single-shot result held until the next start
module avalon_anemo_meter
    import anemo_pkg::*;
#(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int CNT_W       = 8,
    parameter int FILT_LEN    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic        read_n,
    input  logic [1:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        in_anemo
);

    localparam int               GW        = $clog2(GATE_CYCLES + 1);
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    ctrl_t            ctrl;
    logic             start_prev;
    logic [1:0]       state;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] pulse_cnt;
    logic [CNT_W-1:0] frequency;
    logic             data_valid;
    logic             strobe;
    logic             start_rise;
    logic             wr_en;
    logic             rd_en;
    logic             gate_end;
    logic [CNT_W-1:0] pulse_next;
    logic [31:0]      data_word;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    anemo_pulse_filter #(.FILT_LEN(FILT_LEN)) u_filter (
        .clk      (clk),
        .reset    (reset),
        .in_anemo (in_anemo),
        .strobe   (strobe)
    );

    assign wr_en        = chipselect & ~write_n;
    assign rd_en        = chipselect & ~read_n;
    assign start_rise   = ctrl.start_stop & ~start_prev;
    assign gate_end     = (gate_cnt == GATE_LAST);
    assign pulse_next   = (strobe && pulse_cnt != CNT_MAX) ? pulse_cnt + CNT_W'(1) : pulse_cnt;
    assign unused_wdata = &{1'b0, writedata[31:3]};

    // FSM acts on the CTRL value before this cycle's write, so a write landing
    // on the gate's last cycle only takes effect afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl       <= '0;
            start_prev <= 1'b0;
            state      <= ST_IDLE;
            gate_cnt   <= '0;
            pulse_cnt  <= '0;
            frequency  <= '0;
            data_valid <= 1'b0;
        end else begin
            if (wr_en && address == ADDR_CTRL)
                ctrl <= ctrl_t'(writedata[2:0]);
            start_prev <= ctrl.start_stop;
            if (!ctrl.raz_n) begin
                state      <= ST_IDLE;
                gate_cnt   <= '0;
                pulse_cnt  <= '0;
                frequency  <= '0;
                data_valid <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (ctrl.continu || start_rise) begin
                            state     <= ST_MEASURE;
                            gate_cnt  <= '0;
                            pulse_cnt <= '0;
                            if (!ctrl.continu)
                                data_valid <= 1'b0;
                        end
                    end
                    ST_MEASURE: begin
                        if (gate_end) begin
                            frequency  <= pulse_next;
                            data_valid <= 1'b1;
                            gate_cnt   <= '0;
                            pulse_cnt  <= '0;
                            state      <= ctrl.continu ? ST_MEASURE : ST_DONE;
                        end else begin
                            gate_cnt  <= gate_cnt + GW'(1);
                            pulse_cnt <= pulse_next;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        data_word                 = '0;
        data_word[CNT_W-1:0]      = frequency;
        data_word[DATA_VALID_BIT] = data_valid;
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_CTRL: rd_mux = {29'b0, ctrl};
            ADDR_DATA: rd_mux = data_word;
            ADDR_STAT: rd_mux = {29'b0, state, state == ST_MEASURE};
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            readdata <= '0;
        else if (rd_en)
            readdata <= rd_mux;
    end

endmodule

// File: tb/tb_avalon_anemo_meter.sv
// Bench for avalon_anemo_meter: directed scenarios plus random bus/pin traffic,
// checked every cycle against a window-counting model; a CNT_W=3 copy shows saturation.
module tb_avalon_anemo_meter;

    localparam int GATE = 100;
    localparam int FL   = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic        read_n = 1'b1;
    logic [1:0]  address = 2'd0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [31:0] readdata_sat;
    logic        in_anemo = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    avalon_anemo_meter #(.GATE_CYCLES(GATE), .CNT_W(8), .FILT_LEN(FL)) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write_n(write_n),
        .read_n(read_n), .address(address), .writedata(writedata),
        .readdata(readdata), .in_anemo(in_anemo));

    avalon_anemo_meter #(.GATE_CYCLES(GATE), .CNT_W(3), .FILT_LEN(FL)) dut_sat (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write_n(write_n),
        .read_n(read_n), .address(address), .writedata(writedata),
        .readdata(readdata_sat), .in_anemo(in_anemo));

    // ---------------- pin pattern generator ----------------
    int pin_mode = 0;      // 0 low, 1 periodic, 2 burst, 3 glitch, 4 random runs
    int pin_period = 10;
    int pin_burst_n = 0;
    int g_prev = -1, g_ph = 0, g_np = 0, g_run = 0;

    always @(negedge clk) begin
        if (pin_mode != g_prev) begin g_ph = 0; g_np = 0; g_run = 0; end
        g_prev = pin_mode;
        case (pin_mode)
            1: begin in_anemo = (g_ph < pin_period / 2); g_ph++; if (g_ph >= pin_period) g_ph = 0; end
            2: begin
                in_anemo = (g_np < pin_burst_n) && (g_ph < 5);
                g_ph++;
                if (g_ph >= 10) begin g_ph = 0; g_np++; end
            end
            3: begin in_anemo = (g_ph < 2); g_ph++; if (g_ph >= 10) g_ph = 0; end
            4: begin
                if (g_run == 0) begin in_anemo = 1'($urandom_range(0, 1)); g_run = $urandom_range(1, 12); end
                g_run--;
            end
            default: in_anemo = 1'b0;
        endcase
    end

    // ---------------- behavioural model ----------------
    // Filtered level flips once the synchronised pin (two samples old) has shown
    // the other level for FL consecutive samples; a strobe follows one cycle after.
    // Windows are GATE cycles long, counted without bound and clipped on readout.
    bit          m_started = 0;
    logic [2:0]  m_ctrl;
    bit          m_sp, m_run, m_done, m_valid;
    int          m_gpos, m_pcnt, m_freq_raw;
    bit          m_filt, m_filt_d, m_strobe;
    bit          pq[$];
    logic [31:0] exp_rd, exp_rd_sat;

    function automatic logic [31:0] reg_val(input logic [1:0] a, input int mx);
        int code;
        int f;
        code = m_run ? 1 : (m_done ? 2 : 0);
        f = (m_freq_raw > mx) ? mx : m_freq_raw;
        case (a)
            2'd0:    return {29'b0, m_ctrl};
            2'd1:    return (32'(m_valid) << 16) | 32'(f);
            2'd2:    return 32'(code * 2 + (m_run ? 1 : 0));
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        bit sr, flip, n_strobe;
        if (reset) begin
            m_started = 1; m_ctrl = 3'b0; m_sp = 0; m_run = 0; m_done = 0; m_valid = 0;
            m_gpos = 0; m_pcnt = 0; m_freq_raw = 0;
            m_filt = 0; m_filt_d = 0; m_strobe = 0;
            pq.delete();
            repeat (6) pq.push_back(1'b0);
            exp_rd = '0; exp_rd_sat = '0;
        end else begin
            if (chipselect && !read_n) begin
                exp_rd     = reg_val(address, 255);
                exp_rd_sat = reg_val(address, 7);
            end
            sr = m_ctrl[2] && !m_sp;
            if (!m_ctrl[0]) begin
                m_run = 0; m_done = 0; m_gpos = 0; m_pcnt = 0; m_freq_raw = 0; m_valid = 0;
            end else if (m_run) begin
                if (m_gpos == GATE - 1) begin
                    m_freq_raw = m_pcnt + int'(m_strobe);
                    m_valid = 1; m_gpos = 0; m_pcnt = 0;
                    m_run = m_ctrl[1]; m_done = !m_ctrl[1];
                end else begin
                    m_gpos++; m_pcnt += int'(m_strobe);
                end
            end else if (m_ctrl[1] || sr) begin
                m_run = 1; m_done = 0; m_gpos = 0; m_pcnt = 0;
                if (!m_ctrl[1]) m_valid = 0;
            end
            m_sp = m_ctrl[2];
            if (chipselect && !write_n && address == 2'd0) m_ctrl = writedata[2:0];
            pq.push_back(in_anemo);
            if (pq.size() > 8) void'(pq.pop_front());
            flip = 1;
            for (int i = 2; i < 2 + FL; i++)
                if (pq[pq.size() - 1 - i] == m_filt) flip = 0;
            n_strobe = m_filt && !m_filt_d;
            m_filt_d = m_filt;
            if (flip) m_filt = !m_filt;
            m_strobe = n_strobe;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1; write_n = 0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 0; write_n = 1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d, output logic [31:0] ds);
        @(negedge clk);
        chipselect = 1; read_n = 0; address = a;
        @(negedge clk);
        d = readdata; ds = readdata_sat;
        chipselect = 0; read_n = 1;
    endtask

    task automatic rd_chk(input string nm, input logic [1:0] a,
                          input logic [31:0] exp, input logic [31:0] exp_sat);
        logic [31:0] d, ds;
        bus_read(a, d, ds);
        chk(nm, d, exp);
        chk({nm, "_sat"}, ds, exp_sat);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1;
        wait_cyc(2);
        reset = 0;
    endtask

    // ---------------- sequence ----------------
    initial begin
        fork
            forever begin
                @(negedge clk);
                if (m_started) begin
                    chk("model_rd", readdata, exp_rd);
                    chk("model_rd_sat", readdata_sat, exp_rd_sat);
                end
            end
        join_none

        wait_cyc(3);
        reset = 0;
        rd_chk("reset_data", 2'd1, 32'h0, 32'h0);
        rd_chk("reset_stat", 2'd2, 32'h0, 32'h0);

        // continuous, period 10 -> 10 per window; CNT_W=3 copy clips at 7
        pin_mode = 1; pin_period = 10;
        bus_write(2'd0, 32'h3);
        wait_cyc(250);
        rd_chk("cont_data", 2'd1, 32'h0001_000A, 32'h0001_0007);
        rd_chk("cont_stat", 2'd2, 32'h3, 32'h3);
        wait_cyc(100);
        rd_chk("cont_data2", 2'd1, 32'h0001_000A, 32'h0001_0007);

        // single shot with a 7-pulse burst
        bus_write(2'd0, 32'h0);
        pin_mode = 0;
        wait_cyc(20);
        bus_write(2'd0, 32'h1);
        wait_cyc(5);
        rd_chk("ss_idle_stat", 2'd2, 32'h0, 32'h0);
        bus_write(2'd0, 32'h5);
        pin_burst_n = 7; pin_mode = 2;
        wait_cyc(130);
        rd_chk("ss_data", 2'd1, 32'h0001_0007, 32'h0001_0007);
        rd_chk("ss_stat_done", 2'd2, 32'h4, 32'h4);
        pin_mode = 0;
        bus_write(2'd0, 32'h5);
        wait_cyc(20);
        rd_chk("ss_no_restart", 2'd2, 32'h4, 32'h4);
        bus_write(2'd0, 32'h1);
        bus_write(2'd0, 32'h5);
        wait_cyc(3);
        rd_chk("ss_restart_clr", 2'd1, 32'h0000_0007, 32'h0000_0007);
        wait_cyc(120);
        rd_chk("ss_second", 2'd1, 32'h0001_0000, 32'h0001_0000);

        // 2-cycle glitches never pass the filter
        pin_mode = 3;
        bus_write(2'd0, 32'h3);
        wait_cyc(250);
        rd_chk("glitch_data", 2'd1, 32'h0001_0000, 32'h0001_0000);

        // hold-clear mid-gate, then a fresh full gate
        pin_mode = 1; pin_period = 10;
        wait_cyc(150);
        bus_write(2'd0, 32'h0);
        rd_chk("raz_stat", 2'd2, 32'h0, 32'h0);
        rd_chk("raz_data", 2'd1, 32'h0, 32'h0);
        bus_write(2'd0, 32'h3);
        wait_cyc(50);
        rd_chk("restart_mid", 2'd1, 32'h0, 32'h0);
        wait_cyc(100);
        rd_chk("restart_full", 2'd1, 32'h0001_000A, 32'h0001_0007);

        // reset mid-operation
        pulse_reset();
        rd_chk("rst_ctrl", 2'd0, 32'h0, 32'h0);
        rd_chk("rst_data", 2'd1, 32'h0, 32'h0);

        // random traffic, checked by the per-cycle model compare
        pin_mode = 4;
        for (int it = 0; it < 1500; it++) begin
            int op;
            logic [31:0] d, ds;
            op = $urandom_range(0, 99);
            if (op < 8)
                bus_write(2'($urandom_range(0, 3)),
                          {$urandom, 29'b0} | {29'b0, 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0)});
            else if (op < 40)
                bus_read(2'($urandom_range(0, 3)), d, ds);
            else if (op == 40)
                pulse_reset();
            else
                wait_cyc($urandom_range(1, 8));
        end

        wait_cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
